// File: rtl/bin8_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3) feeding the seven-segment display stage.
// One conversion per start; results and sign are held until the next conversion completes.
//
// state  | meaning
// IDLE   | waiting for start; captures data_in/signed_mode on the accepting edge
// LOAD   | forms the magnitude and sign, clears the scratch register and counter
// SHIFT  | ITER cycles of add-3-then-shift-left
// FINISH | publishes digits and sign, pulses done
module bin8_to_bcd_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic [3:0]       bcd_hund,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_units
);

    localparam int ITER = WIDTH;
    localparam int SW = WIDTH + 12;
    localparam logic [3:0] CNT_LAST = 4'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data_cap;
    logic             signed_cap;
    logic             sign_int;
    logic [WIDTH-1:0] mag;
    logic [SW-1:0]    scratch;
    logic [SW-1:0]    scratch_adj;
    logic [3:0]       cnt;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mag = data_cap;
        if (signed_cap && data_cap[WIDTH-1])
            mag = (~data_cap) + {{(WIDTH-1){1'b0}}, 1'b1};
    end

    always_comb begin
        scratch_adj = scratch;
        scratch_adj[WIDTH +: 4]     = add3(scratch[WIDTH +: 4]);
        scratch_adj[WIDTH + 4 +: 4] = add3(scratch[WIDTH + 4 +: 4]);
        scratch_adj[WIDTH + 8 +: 4] = add3(scratch[WIDTH + 8 +: 4]);
    end

    // busy/done are registered so that they trail the state by one edge,
    // which lines the done pulse up with the digit update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_cap   <= '0;
            signed_cap <= 1'b0;
            sign_int   <= 1'b0;
            scratch    <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sign       <= 1'b0;
            bcd_hund   <= '0;
            bcd_tens   <= '0;
            bcd_units  <= '0;
        end else begin
            busy <= (state == LOAD) || (state == SHIFT);
            done <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        data_cap   <= data_in;
                        signed_cap <= signed_mode;
                    end
                end
                LOAD: begin
                    sign_int <= signed_cap & data_cap[WIDTH-1];
                    scratch  <= {12'b0, mag};
                    cnt      <= '0;
                end
                SHIFT: begin
                    scratch <= {scratch_adj[SW-2:0], 1'b0};
                    cnt     <= cnt + 4'd1;
                end
                FINISH: begin
                    bcd_hund  <= scratch[WIDTH + 8 +: 4];
                    bcd_tens  <= scratch[WIDTH + 4 +: 4];
                    bcd_units <= scratch[WIDTH +: 4];
                    sign      <= sign_int;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin8_to_bcd_seq.sv
// Directed self-checking bench for bin8_to_bcd_seq (WIDTH=8).
module tb_bin8_to_bcd_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       signed_mode;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic       sign;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;

    int checks = 0;
    int errors = 0;

    bin8_to_bcd_seq #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .signed_mode(signed_mode),
        .data_in(data_in),
        .busy(busy),
        .done(done),
        .sign(sign),
        .bcd_hund(bcd_hund),
        .bcd_tens(bcd_tens),
        .bcd_units(bcd_units)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a one-cycle start; returns just after the accepting edge k.
    task automatic launch(input logic [7:0] d, input logic sm);
        @(negedge clk);
        start = 1'b1;
        data_in = d;
        signed_mode = sm;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        int done_seen;
        int busy_seen;
        done_seen = 0;
        busy_seen = 0;
        rst_n = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        data_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL reset_done_idle: done seen %0d cycles, required 0", done_seen);
        end
        checks++;
        if (busy_seen !== 0) begin
            errors++;
            $display("FAIL reset_busy_idle: busy seen %0d cycles, required 0", busy_seen);
        end
        checks++;
        if ({sign, bcd_hund, bcd_tens, bcd_units} !== 13'h0) begin
            errors++;
            $display("FAIL reset_digits: got sign %0b %0d,%0d,%0d required 0 0,0,0",
                     sign, bcd_hund, bcd_tens, bcd_units);
        end
    endtask

    task automatic test_unsigned_max();
        launch(8'hFF, 1'b0);
        for (int j = 1; j <= 11; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== (j <= 9)) begin
                errors++;
                $display("FAIL umax_busy edge k+%0d: got %0b required %0b", j, busy, (j <= 9));
            end
            checks++;
            if (done !== (j == 10)) begin
                errors++;
                $display("FAIL umax_done edge k+%0d: got %0b required %0b", j, done, (j == 10));
            end
        end
        checks++;
        if ({sign, bcd_hund, bcd_tens, bcd_units} !== {1'b0, 4'd2, 4'd5, 4'd5}) begin
            errors++;
            $display("FAIL umax_digits: got sign %0b %0d,%0d,%0d required 0 2,5,5",
                     sign, bcd_hund, bcd_tens, bcd_units);
        end
    endtask

    task automatic test_signed_extremes();
        logic [7:0]  vin [3];
        logic [12:0] vexp [3];
        int          at;
        vin[0] = 8'h80; vexp[0] = {1'b1, 4'd1, 4'd2, 4'd8};
        vin[1] = 8'h7F; vexp[1] = {1'b0, 4'd1, 4'd2, 4'd7};
        vin[2] = 8'hFF; vexp[2] = {1'b1, 4'd0, 4'd0, 4'd1};
        for (int v = 0; v < 3; v++) begin
            launch(vin[v], 1'b1);
            at = -1;
            for (int j = 1; j <= 30; j++) begin
                @(posedge clk);
                #1;
                if (done) begin
                    at = j;
                    break;
                end
            end
            checks++;
            if (at !== 10) begin
                errors++;
                $display("FAIL signed_latency %02h: done at k+%0d required k+10", vin[v], at);
            end
            checks++;
            if ({sign, bcd_hund, bcd_tens, bcd_units} !== vexp[v]) begin
                errors++;
                $display("FAIL signed_digits %02h: got sign %0b %0d,%0d,%0d required sign %0b %0d,%0d,%0d",
                         vin[v], sign, bcd_hund, bcd_tens, bcd_units,
                         vexp[v][12], vexp[v][11:8], vexp[v][7:4], vexp[v][3:0]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int cnt_done;
        int first;
        cnt_done = 0;
        first = -1;
        launch(8'd42, 1'b0);
        for (int j = 1; j <= 25; j++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cnt_done++;
                if (first < 0) first = j;
            end
            if (j == 3) begin
                start = 1'b1;
                data_in = 8'd99;
            end
            if (j == 4) start = 1'b0;
        end
        checks++;
        if (cnt_done !== 1 || first !== 10) begin
            errors++;
            $display("FAIL busy_ignore_start: %0d dones first at k+%0d, required 1 at k+10", cnt_done, first);
        end
        checks++;
        if ({sign, bcd_hund, bcd_tens, bcd_units} !== {1'b0, 4'd0, 4'd4, 4'd2}) begin
            errors++;
            $display("FAIL busy_ignore_digits: got %0d,%0d,%0d required 0,4,2",
                     bcd_hund, bcd_tens, bcd_units);
        end
    endtask

    task automatic test_input_change_hold();
        int at;
        int hold_bad;
        at = -1;
        launch(8'd200, 1'b0);
        for (int j = 1; j <= 30; j++) begin
            @(posedge clk);
            #1;
            if (j == 1) begin
                data_in = 8'd7;
                signed_mode = 1'b1;
            end
            if (done) begin
                at = j;
                break;
            end
        end
        signed_mode = 1'b0;
        checks++;
        if (at !== 10 || {sign, bcd_hund, bcd_tens, bcd_units} !== {1'b0, 4'd2, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL midchange_200: done at k+%0d digits %0b %0d,%0d,%0d required k+10 0 2,0,0",
                     at, sign, bcd_hund, bcd_tens, bcd_units);
        end
        at = -1;
        hold_bad = 0;
        launch(8'd7, 1'b0);
        for (int j = 1; j <= 30; j++) begin
            @(posedge clk);
            #1;
            if (done) begin
                at = j;
                break;
            end
            if ({bcd_hund, bcd_tens, bcd_units} !== {4'd2, 4'd0, 4'd0}) hold_bad++;
        end
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL output_hold: digits changed in %0d cycles before done, required 0", hold_bad);
        end
        checks++;
        if (at !== 10 || {sign, bcd_hund, bcd_tens, bcd_units} !== {1'b0, 4'd0, 4'd0, 4'd7}) begin
            errors++;
            $display("FAIL hold_then_7: done at k+%0d digits %0d,%0d,%0d required k+10 0,0,7",
                     at, bcd_hund, bcd_tens, bcd_units);
        end
    endtask

    task automatic test_async_reset();
        int done_seen;
        int at;
        done_seen = 0;
        at = -1;
        launch(8'd99, 1'b1);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sign, bcd_hund, bcd_tens, bcd_units} !== 15'h0) begin
            errors++;
            $display("FAIL async_reset_clear: busy %0b done %0b sign %0b %0d,%0d,%0d required all 0",
                     busy, done, sign, bcd_hund, bcd_tens, bcd_units);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL async_reset_no_done: done seen %0d times, required 0", done_seen);
        end
        launch(8'd13, 1'b0);
        for (int j = 1; j <= 30; j++) begin
            @(posedge clk);
            #1;
            if (done) begin
                at = j;
                break;
            end
        end
        checks++;
        if (at !== 10 || {sign, bcd_hund, bcd_tens, bcd_units} !== {1'b0, 4'd0, 4'd1, 4'd3}) begin
            errors++;
            $display("FAIL after_reset_13: done at k+%0d digits %0d,%0d,%0d required k+10 0,1,3",
                     at, bcd_hund, bcd_tens, bcd_units);
        end
    endtask

    task automatic test_back_to_back();
        int cnt_done;
        int d1;
        int d2;
        cnt_done = 0;
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        start = 1'b1;
        data_in = 8'd123;
        signed_mode = 1'b0;
        @(posedge clk);
        for (int j = 1; j <= 25; j++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cnt_done++;
                if (d1 < 0) d1 = j;
                else if (d2 < 0) d2 = j;
            end
        end
        start = 1'b0;
        checks++;
        if (cnt_done !== 2 || d1 !== 10 || d2 !== 21) begin
            errors++;
            $display("FAIL back_to_back: %0d dones at k+%0d,k+%0d required 2 at k+10,k+21", cnt_done, d1, d2);
        end
        checks++;
        if ({sign, bcd_hund, bcd_tens, bcd_units} !== {1'b0, 4'd1, 4'd2, 4'd3}) begin
            errors++;
            $display("FAIL back_to_back_digits: got %0d,%0d,%0d required 1,2,3",
                     bcd_hund, bcd_tens, bcd_units);
        end
        repeat (15) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_extremes();
        test_start_while_busy();
        test_input_change_hold();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin8_to_bcd_seq.md
Name: bin8_to_bcd_seq

Overview:
Sequential binary-to-BCD converter (shift-add-3 / double-dabble) that sits directly upstream of the 4-digit seven-segment display stage.
- Takes the 8-bit result of the A/B arithmetic path.
- Produces a sign flag plus hundreds/tens/units BCD digits.
- The display multiplexer shows these as sign, hundreds, tens, units.
- A start/done handshake lets the arithmetic unit launch one conversion at a time; results are held stable between conversions.

Parameters:
- WIDTH, 8, input word width. Legal range 4..8. Three BCD digits always suffice.
- ITER, WIDTH, number of shift iterations. Derived; must not be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request. Sampled only in IDLE.
- signed_mode  input  1  1 = data_in is two's complement; 0 = unsigned.
- data_in  input  WIDTH  value to convert. Sampled on the accepting start edge.
- busy  output  1  high while a conversion is in progress (LOAD..SHIFT).
- done  output  1  one-cycle pulse: new digits valid.
- sign  output  1  1 = negative result.
- bcd_hund  output  4  hundreds digit, 0..2.
- bcd_tens  output  4  tens digit, 0..9.
- bcd_units  output  4  units digit, 0..9.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sign=0; all digit outputs 0; internal shift register and counter 0. Takes effect immediately, including mid-conversion. After reset release, no done until a new start.
- FSM states: IDLE, LOAD, SHIFT, FINISH.
- IDLE:
  - start=1 at edge k captures data_in and signed_mode; next state LOAD.
  - start=0 stays in IDLE.
- LOAD (one cycle):
  - mag = data_in if signed_mode=0 or data_in[WIDTH-1]=0; otherwise mag = two's-complement negation of data_in, taken as WIDTH-bit unsigned.
  - -128 therefore yields mag=128.
  - Latch sign_int = signed_mode & data_in[WIDTH-1].
  - Scratch = {12'b0, mag}; counter=0; next state SHIFT.
- SHIFT (exactly ITER cycles):
  - Each cycle, every BCD nibble >=5 gets +3, then the whole scratch shifts left by 1.
  - The counter increments. When counter reaches ITER-1, next state is FINISH.
- FINISH (one cycle):
  - Copy scratch nibbles to bcd_hund/bcd_tens/bcd_units and sign_int to sign.
  - done=1 this cycle only; next state IDLE.
- Latency: start accepted at edge k; busy=1 from edge k+1 through edge k+ITER+1; outputs update and done rises at edge k+ITER+2 (k+10 for WIDTH=8); done falls at the following edge.
- busy is low in FINISH and IDLE.
- start while busy or in FINISH is ignored, not queued.
- start held high continuously re-triggers one cycle after FINISH (back-to-back conversions every ITER+3 cycles).
- data_in/signed_mode changes after the accepting edge do not affect the conversion in flight.
- Outputs hold their last converted value until the next FINISH; they never show intermediate values.
- Unsigned 255 -> 2,5,5 sign 0.
- Signed 8'hFF -> sign 1, 0,0,1.
- Zero -> sign 0, 0,0,0 (no negative zero).

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, start=0 for 20 cycles -> busy=0, done never asserted, digits 0,0,0, sign 0.
- Unsigned max: signed_mode=0, data_in=8'hFF, start pulse at edge k -> done high only at edge k+10; hund=2, tens=5, units=5, sign=0; busy high for edges k+1..k+9.
- Signed extremes:
  - data_in=8'h80, signed_mode=1 -> sign=1, 1,2,8.
  - data_in=8'h7F -> sign=0, 1,2,7.
  - data_in=8'hFF -> sign=1, 0,0,1.
- Start while busy: start 8'd42, then at edge k+4 pulse start with 8'd99 -> single done at k+10 showing 0,4,2; no second done until a new start in IDLE.
- Input change mid-conversion and output hold: start with 8'd200, change data_in to 8'd7 at k+2 -> result 2,0,0. Then start 8'd7; digits stay 2,0,0 until that conversion's done, then show 0,0,7.
- Async reset mid-conversion: assert rst_n low at edge k+5 between clock edges -> busy, done and digits clear immediately without waiting for clk. After release, no done occurs; a fresh start of 8'd13 -> 0,1,3 after 10 cycles.
